// File: rtl/binary_encoder_queue_pkg.sv
// Shared widths, FSM encoding and a population-count helper for the
// binary encoder queue.
package binary_encoder_queue_pkg;

    localparam int IDX_W = 5;
    localparam int N_REQ = 32;
    localparam int CNT_W = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Number of set bits in a request vector; result fits 0..32 in CNT_W bits.
    function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] vec);
        logic [CNT_W-1:0] total;
        total = '0;
        for (int i = 0; i < N_REQ; i++) begin
            total = total + CNT_W'(vec[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/binary_encoder_queue_priority_pick.sv
// Combinational circular priority picker: returns the first set bit of vec
// found scanning from index start upward, wrapping 31 to 0.
module priority_pick
    import binary_encoder_queue_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan all offsets from start; the first hit wins and later hits are ignored.
    always_comb begin
        logic [IDX_W-1:0] w_pos;
        idx   = '0;
        any   = 1'b0;
        w_pos = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = start + IDX_W'(i);
            if (!any && vec[w_pos]) begin
                idx = w_pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/binary_encoder_queue.sv
// Pending-request queue that hands out one grant at a time as a binary index.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant outstanding; a new grant is issued when E=1 and
//            | something is pending
//   ST_GRANT | O/V held stable until the consumer acks
//
// RR=0 picks the lowest pending index; RR=1 scans from a rotating pointer
// that moves to one past the last acked index.
module binary_encoder_queue
    import binary_encoder_queue_pkg::*;
#(
    parameter int RR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] R,
    input  logic             E,
    input  logic             ack,
    output logic [IDX_W-1:0] O,
    output logic             V,
    output logic [CNT_W-1:0] cnt
);

    state_t           r_state;
    logic [N_REQ-1:0] r_pending;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic [IDX_W-1:0] r_ptr;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_valid_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_pending_nxt;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_accept;

    // Pointer only matters in round-robin mode; fixed priority always scans from 0.
    assign w_start = (RR != 0) ? r_ptr : '0;

    priority_pick u_pick (
        .vec   (r_pending),
        .start (w_start),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    // An ack only counts against a valid grant; a same-cycle request re-arms the bit.
    always_comb begin
        w_accept      = r_valid && ack;
        w_clr         = '0;
        if (w_accept) begin
            w_clr[r_idx] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_clr) | R;
    end

    // Next-state and registered grant outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (E && w_pick_any) begin
                    w_idx_nxt   = w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (RR != 0) begin
                        w_ptr_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register; reset clears everything, including a grant in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_cnt     <= popcount(w_pending_nxt);
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    assign O   = r_idx;
    assign V   = r_valid;
    assign cnt = r_cnt;

endmodule

// File: tb/tb_binary_encoder_queue.sv
// Directed bench: one fixed-priority and one round-robin instance driven
// by a linear sequence of steps with hand-computed expectations.
module tb_binary_encoder_queue;

    logic        clk;
    logic        reset;
    logic [31:0] R0, R1;
    logic        E0, E1;
    logic        ack0, ack1;
    logic [4:0]  O0, O1;
    logic        V0, V1;
    logic [5:0]  cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    binary_encoder_queue #(.RR(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .R     (R0),
        .E     (E0),
        .ack   (ack0),
        .O     (O0),
        .V     (V0),
        .cnt   (cnt0)
    );

    binary_encoder_queue #(.RR(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .R     (R1),
        .E     (E1),
        .ack   (ack1),
        .O     (O1),
        .V     (V1),
        .cnt   (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        R0 = '0; E0 = 1'b0; ack0 = 1'b0;
        R1 = '0; E1 = 1'b0; ack1 = 1'b0;
        #3;
        check("rst_V", 32'(V0), 32'd0);
        check("rst_O", 32'(O0), 32'd0);
        check("rst_cnt", 32'(cnt0), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Two requests in one pulse, fixed priority: 2 then 5.
        E0 = 1'b1; R0 = 32'h0000_0024;
        tick();
        check("a_cnt_load", 32'(cnt0), 32'd2);
        check("a_V_latency", 32'(V0), 32'd0);
        R0 = '0;
        tick();
        check("a_V_first", 32'(V0), 32'd1);
        check("a_O_first", 32'(O0), 32'd2);
        check("a_cnt_first", 32'(cnt0), 32'd2);
        ack0 = 1'b1;
        tick();
        check("a_V_ack1", 32'(V0), 32'd0);
        check("a_cnt_ack1", 32'(cnt0), 32'd1);
        ack0 = 1'b0;
        tick();
        check("a_V_second", 32'(V0), 32'd1);
        check("a_O_second", 32'(O0), 32'd5);
        ack0 = 1'b1;
        tick();
        check("a_V_done", 32'(V0), 32'd0);
        check("a_cnt_done", 32'(cnt0), 32'd0);
        ack0 = 1'b0;

        // ack with no valid grant must not clear anything.
        E0 = 1'b0; R0 = 32'h0000_0008;
        tick();
        check("b_cnt_load", 32'(cnt0), 32'd1);
        R0 = '0; ack0 = 1'b1;
        tick();
        check("b_cnt_stray_ack", 32'(cnt0), 32'd1);
        check("b_V_stray_ack", 32'(V0), 32'd0);
        ack0 = 1'b0; E0 = 1'b1;
        tick();
        check("b_V_grant", 32'(V0), 32'd1);
        check("b_O_grant", 32'(O0), 32'd3);
        ack0 = 1'b1;
        tick();
        check("b_cnt_done", 32'(cnt0), 32'd0);
        ack0 = 1'b0;

        // Same-cycle ack and request of index 7: bit stays pending, re-granted.
        R0 = 32'h0000_0080;
        tick();
        R0 = '0;
        tick();
        check("c_O_grant", 32'(O0), 32'd7);
        check("c_cnt_grant", 32'(cnt0), 32'd1);
        ack0 = 1'b1; R0 = 32'h0000_0080;
        tick();
        check("c_V_ack", 32'(V0), 32'd0);
        check("c_cnt_kept", 32'(cnt0), 32'd1);
        ack0 = 1'b0; R0 = '0;
        tick();
        check("c_V_regrant", 32'(V0), 32'd1);
        check("c_O_regrant", 32'(O0), 32'd7);
        ack0 = 1'b1;
        tick();
        check("c_cnt_done", 32'(cnt0), 32'd0);
        ack0 = 1'b0;

        // Grant held while E drops and R changes; then reset mid-grant.
        R0 = 32'h0000_0012;
        tick();
        R0 = '0;
        tick();
        check("d_O_grant", 32'(O0), 32'd1);
        check("d_cnt_grant", 32'(cnt0), 32'd2);
        E0 = 1'b0; R0 = 32'h0000_0001;
        tick();
        check("d_O_hold1", 32'(O0), 32'd1);
        check("d_V_hold1", 32'(V0), 32'd1);
        check("d_cnt_hold1", 32'(cnt0), 32'd3);
        R0 = 32'h0000_0008;
        tick();
        check("d_O_hold2", 32'(O0), 32'd1);
        check("d_V_hold2", 32'(V0), 32'd1);
        check("d_cnt_hold2", 32'(cnt0), 32'd4);
        R0 = '0;
        #2;
        reset = 1'b1;
        #1;
        check("d_async_V", 32'(V0), 32'd0);
        check("d_async_O", 32'(O0), 32'd0);
        check("d_async_cnt", 32'(cnt0), 32'd0);
        R0 = 32'hFFFF_FFFF; ack0 = 1'b1;
        tick();
        check("d_rst_ignore_R", 32'(cnt0), 32'd0);
        check("d_rst_V", 32'(V0), 32'd0);
        reset = 1'b0; R0 = '0; ack0 = 1'b0;
        tick();

        // All 32 pending with E low; duplicates absorbed; then grants 0, 1.
        E0 = 1'b0; R0 = 32'hFFFF_FFFF;
        tick();
        check("e_cnt_full", 32'(cnt0), 32'd32);
        check("e_V_gated", 32'(V0), 32'd0);
        tick();
        check("e_cnt_dup", 32'(cnt0), 32'd32);
        R0 = '0;
        tick();
        check("e_V_still_gated", 32'(V0), 32'd0);
        E0 = 1'b1;
        tick();
        check("e_V_grant", 32'(V0), 32'd1);
        check("e_O_grant", 32'(O0), 32'd0);
        ack0 = 1'b1;
        tick();
        check("e_cnt_31", 32'(cnt0), 32'd31);
        ack0 = 1'b0;
        tick();
        check("e_O_next", 32'(O0), 32'd1);
        ack0 = 1'b1;
        tick();
        check("e_cnt_30", 32'(cnt0), 32'd30);
        ack0 = 1'b0; E0 = 1'b0;

        // Round-robin instance: 0, then 31, pointer wraps to 0.
        E1 = 1'b1; R1 = 32'h8000_0001;
        tick();
        check("f_cnt_load", 32'(cnt1), 32'd2);
        R1 = '0;
        tick();
        check("f_O_first", 32'(O1), 32'd0);
        check("f_V_first", 32'(V1), 32'd1);
        ack1 = 1'b1;
        tick();
        check("f_V_ack", 32'(V1), 32'd0);
        ack1 = 1'b0;
        tick();
        check("f_O_wrap", 32'(O1), 32'd31);
        ack1 = 1'b1;
        tick();
        check("f_cnt_empty", 32'(cnt1), 32'd0);
        ack1 = 1'b0; R1 = 32'h0000_0003;
        tick();
        R1 = '0;
        tick();
        check("f_O_after_wrap", 32'(O1), 32'd0);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        tick();
        check("f_O_then_1", 32'(O1), 32'd1);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0; R1 = 32'h0000_0005;
        tick();
        R1 = '0;
        tick();
        check("f_O_rr_skip0", 32'(O1), 32'd2);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        tick();
        check("f_O_rr_wrap0", 32'(O1), 32'd0);
        ack1 = 1'b1;
        tick();
        check("f_cnt_done", 32'(cnt1), 32'd0);
        ack1 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
